// File: rtl/vga_sync_rx_if.sv
// VGA receive bus: sync/colour stream from the timing generator plus the
// recovered pixel coordinates, colour and format status returned to consumers.
interface vga_sync_rx_if;
    logic       pix_en;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;
    logic       pix_valid;
    logic       frame_start;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       locked;
    logic       err;

    modport master (
        output pix_en, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
        input  pix_x, pix_y, pix_r, pix_g, pix_b, pix_valid, frame_start,
               line_len, frame_lines, locked, err
    );

    modport slave (
        input  pix_en, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
        output pix_x, pix_y, pix_r, pix_g, pix_b, pix_valid, frame_start,
               line_len, frame_lines, locked, err
    );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA timing recovery: rebuilds h/v coordinates from HS/VS, measures line and
// frame length, locks onto a stable format and reports active pixels.
module vga_sync_rx #(
    parameter int unsigned H_ACTIVE_START = 32'd144,
    parameter int unsigned H_ACTIVE       = 32'd640,
    parameter int unsigned V_ACTIVE_START = 32'd35,
    parameter int unsigned V_ACTIVE       = 32'd480
) (
    input logic          CLOCK_50,
    input logic          reset,
    vga_sync_rx_if.slave vga
);
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0] H_LO  = 10'(H_ACTIVE_START);
    localparam logic [9:0] H_HI  = 10'(H_ACTIVE_START + H_ACTIVE);
    localparam logic [9:0] V_LO  = 10'(V_ACTIVE_START);
    localparam logic [9:0] V_HI  = 10'(V_ACTIVE_START + V_ACTIVE);
    localparam logic [9:0] C_MAX = 10'd1023;

    logic        smp_hs_r, smp_vs_r, smp_vld_r, prv_hs_r, prv_vs_r;
    logic [23:0] smp_rgb_r;
    logic [9:0]  h_r, v_r;
    logic        seen_hs_r, seen_vs_r;
    state_t      state_r;
    logic [9:0]  ref_len_r, ref_lines_r;
    logic        len_ok_r, lines_ok_r, line_bad_r;
    logic [9:0]  pix_x_r, pix_y_r, line_len_r, frame_lines_r;
    logic [7:0]  pix_r_r, pix_g_r, pix_b_r;
    logic        pix_valid_r, frame_start_r, locked_r, err_r;

    logic        proc_s, hs_rise_s, vs_rise_s, vs_evt_s;
    logic [9:0]  h_cur_s, v_cur_s, meas_len_s, meas_lines_s;
    logic        len_chk_s, lines_chk_s, len_mis_s, frame_bad_s, fail_s, active_s;

    // Decode the held sample: edges, its coordinates and the lock checks.
    always_comb begin
        proc_s       = vga.pix_en & smp_vld_r;
        hs_rise_s    = smp_hs_r & ~prv_hs_r;
        vs_rise_s    = smp_vs_r & ~prv_vs_r;
        vs_evt_s     = vs_rise_s & hs_rise_s;
        if (hs_rise_s) begin
            h_cur_s = 10'd0;
        end else if (h_r == C_MAX) begin
            h_cur_s = C_MAX;
        end else begin
            h_cur_s = h_r + 10'd1;
        end
        if (!hs_rise_s) begin
            v_cur_s = v_r;
        end else if (vs_rise_s) begin
            v_cur_s = 10'd0;
        end else if (v_r == C_MAX) begin
            v_cur_s = C_MAX;
        end else begin
            v_cur_s = v_r + 10'd1;
        end
        meas_len_s   = h_r + 10'd1;
        meas_lines_s = v_r + 10'd1;
        len_chk_s    = hs_rise_s & seen_hs_r;
        lines_chk_s  = vs_evt_s & seen_vs_r;
        len_mis_s    = len_ok_r & (meas_len_s != ref_len_r);
        frame_bad_s  = line_bad_r | ~len_ok_r | len_mis_s;
        // An HS rise forces h to 0, so it always wins over the h timeout.
        fail_s       = (len_chk_s & (meas_len_s != ref_len_r))
                     | (lines_chk_s & (meas_lines_s != ref_lines_r))
                     | (h_cur_s == C_MAX) | (v_cur_s == C_MAX);
        active_s     = (state_r == ST_LOCKED) & ~fail_s
                     & (h_cur_s >= H_LO) & (h_cur_s < H_HI)
                     & (v_cur_s >= V_LO) & (v_cur_s < V_HI);
    end

    // Input sampling register and previous-sync history.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            smp_hs_r  <= 1'b0;
            smp_vs_r  <= 1'b0;
            smp_rgb_r <= 24'd0;
            smp_vld_r <= 1'b0;
            prv_hs_r  <= 1'b0;
            prv_vs_r  <= 1'b0;
        end else if (vga.pix_en) begin
            smp_hs_r  <= vga.VGA_HS;
            smp_vs_r  <= vga.VGA_VS;
            smp_rgb_r <= {vga.VGA_R, vga.VGA_G, vga.VGA_B};
            smp_vld_r <= 1'b1;
            prv_hs_r  <= smp_hs_r;
            prv_vs_r  <= smp_vs_r;
        end
    end

    // Position counters and line/frame length measurement.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            h_r           <= 10'd0;
            v_r           <= 10'd0;
            seen_hs_r     <= 1'b0;
            seen_vs_r     <= 1'b0;
            line_len_r    <= 10'd0;
            frame_lines_r <= 10'd0;
        end else if (proc_s) begin
            h_r <= h_cur_s;
            v_r <= v_cur_s;
            if (hs_rise_s) seen_hs_r <= 1'b1;
            if (vs_evt_s) seen_vs_r <= 1'b1;
            if (len_chk_s) line_len_r <= meas_len_s;
            if (lines_chk_s) frame_lines_r <= meas_lines_s;
        end
    end

    // Lock FSM: two consecutive matching frames lock, any deviation drops lock.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_r     <= ST_SEARCH;
            ref_len_r   <= 10'd0;
            ref_lines_r <= 10'd0;
            len_ok_r    <= 1'b0;
            lines_ok_r  <= 1'b0;
            line_bad_r  <= 1'b0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
        end else if (proc_s) begin
            case (state_r)
                ST_SEARCH: begin
                    if (vs_evt_s) begin
                        state_r    <= ST_MEASURE;
                        len_ok_r   <= 1'b0;
                        lines_ok_r <= 1'b0;
                        line_bad_r <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (vs_evt_s) begin
                        if (frame_bad_s) begin
                            ref_len_r  <= meas_len_s;
                            len_ok_r   <= 1'b1;
                            lines_ok_r <= 1'b0;
                            line_bad_r <= 1'b0;
                        end else if (!lines_ok_r) begin
                            ref_lines_r <= meas_lines_s;
                            lines_ok_r  <= 1'b1;
                        end else if (meas_lines_s == ref_lines_r) begin
                            state_r  <= ST_LOCKED;
                            locked_r <= 1'b1;
                        end else begin
                            ref_lines_r <= meas_lines_s;
                        end
                    end else if (hs_rise_s) begin
                        if (!len_ok_r) begin
                            ref_len_r <= meas_len_s;
                            len_ok_r  <= 1'b1;
                        end else if (len_mis_s) begin
                            ref_len_r  <= meas_len_s;
                            line_bad_r <= 1'b1;
                            lines_ok_r <= 1'b0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (fail_s) begin
                        state_r  <= ST_SEARCH;
                        locked_r <= 1'b0;
                        err_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_SEARCH;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    // Pixel report and frame_start pulse; coordinates/colour hold between pulses.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            pix_x_r       <= 10'd0;
            pix_y_r       <= 10'd0;
            pix_r_r       <= 8'd0;
            pix_g_r       <= 8'd0;
            pix_b_r       <= 8'd0;
            pix_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            pix_valid_r   <= proc_s & active_s;
            frame_start_r <= proc_s & vs_rise_s;
            if (proc_s && active_s) begin
                pix_x_r <= h_cur_s - H_LO;
                pix_y_r <= v_cur_s - V_LO;
                pix_r_r <= smp_rgb_r[23:16];
                pix_g_r <= smp_rgb_r[15:8];
                pix_b_r <= smp_rgb_r[7:0];
            end
        end
    end

    assign vga.pix_x       = pix_x_r;
    assign vga.pix_y       = pix_y_r;
    assign vga.pix_r       = pix_r_r;
    assign vga.pix_g       = pix_g_r;
    assign vga.pix_b       = pix_b_r;
    assign vga.pix_valid   = pix_valid_r;
    assign vga.frame_start = frame_start_r;
    assign vga.line_len    = line_len_r;
    assign vga.frame_lines = frame_lines_r;
    assign vga.locked      = locked_r;
    assign vga.err         = err_r;
endmodule
